// File: rtl/dual_fetch_queue.sv
// -----------------------------------------------------------------------------
// dual_fetch_queue
//   Dual-issue fetch stage plus circular instruction queue feeding decode.
//   Each cycle the fetch pair (PC1, PC1+4) is presented to the instruction
//   cache. When the cache hits and there is room for two entries, the returned
//   pair is written at the tail. Decode sees the two oldest entries and may
//   consume 0, 1 or 2 of them per cycle. A redirect empties the queue and
//   restarts fetch at the redirect target.
//
// Ports
//   CLOCK, RESET_N             clock (rising edge), async active-low reset
//   PC1, PC2                   fetch pair addresses to the cache
//   ic_inst1, ic_inst2         cache data for PC1/PC2
//   ic_ready                   cache data valid this cycle
//   dec_valid1, dec_valid2     head / head+1 entries valid
//   IC1, IC2, dec_pc1, dec_pc2 head / head+1 instruction and PC (0 if invalid)
//   dec_take                   entries consumed by decode this cycle
//   redirect_valid, redirect_pc  flush and restart fetch
//   q_count                    current occupancy
// -----------------------------------------------------------------------------
module dual_fetch_queue #(
    parameter int              DEPTH    = 8,
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                     CLOCK,
    input  logic                     RESET_N,
    output logic [PC_W-1:0]          PC1,
    output logic [PC_W-1:0]          PC2,
    input  logic [31:0]              ic_inst1,
    input  logic [31:0]              ic_inst2,
    input  logic                     ic_ready,
    output logic                     dec_valid1,
    output logic                     dec_valid2,
    output logic [31:0]              IC1,
    output logic [31:0]              IC2,
    output logic [PC_W-1:0]          dec_pc1,
    output logic [PC_W-1:0]          dec_pc2,
    input  logic [1:0]               dec_take,
    input  logic                     redirect_valid,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Queue payload: no reset needed, validity comes from count_q.
    logic [PC_W-1:0]  pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];

    logic [1:0]       valid_cnt;
    logic [1:0]       take_eff;
    logic             push;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;

    assign head_p1 = head_q + PTR_W'(1);
    assign tail_p1 = tail_q + PTR_W'(1);

    // Fetch request / push decision
    always_comb begin
        valid_cnt = (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];
        // An over-large dec_take is clamped so the pointers never pass the tail.
        take_eff  = (dec_take > valid_cnt) ? valid_cnt : dec_take;
        // Room is judged on the pre-pop occupancy; a same-cycle pop does not help.
        push      = ic_ready && !redirect_valid && (count_q <= CNT_W'(DEPTH - 2));

        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            head_d  = head_q + PTR_W'(take_eff);
            count_d = count_q - CNT_W'(take_eff);
            if (push) begin
                fetch_pc_d = fetch_pc_q + PC_W'(8);
                tail_d     = tail_q + PTR_W'(2);
                count_d    = count_q + CNT_W'(2) - CNT_W'(take_eff);
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Queue write: the pair may straddle the wrap point.
    always_ff @(posedge CLOCK) begin
        if (push) begin
            pc_mem[tail_q]    <= fetch_pc_q;
            inst_mem[tail_q]  <= ic_inst1;
            pc_mem[tail_p1]   <= fetch_pc_q + PC_W'(4);
            inst_mem[tail_p1] <= ic_inst2;
        end
    end

    // Decode read: registered state only, no fetch-to-decode bypass.
    assign PC1        = fetch_pc_q;
    assign PC2        = fetch_pc_q + PC_W'(4);
    assign q_count    = count_q;
    assign dec_valid1 = (count_q >= CNT_W'(1));
    assign dec_valid2 = (count_q >= CNT_W'(2));
    assign IC1        = dec_valid1 ? inst_mem[head_q]  : '0;
    assign dec_pc1    = dec_valid1 ? pc_mem[head_q]    : '0;
    assign IC2        = dec_valid2 ? inst_mem[head_p1] : '0;
    assign dec_pc2    = dec_valid2 ? pc_mem[head_p1]   : '0;

    // Decode may never consume more entries than are valid.
    take_legal_a: assert property (@(posedge CLOCK) disable iff (!RESET_N || redirect_valid)
                                   dec_take <= valid_cnt);

endmodule
